// File: rtl/parking_lot_ctrl.sv
// Parking lot gate sequencer: decodes entry/exit sensor
// sequences and tracks occupancy with sticky error flag.
module parking_lot_ctrl #(
  parameter int CAPACITY = 16,
  localparam int CW = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a,
  input  logic          b,
  output logic          enter,
  output logic          exit,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE,
    IN1,
    IN2,
    IN3,
    OUT1,
    OUT2,
    OUT3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic a_m;
  logic a_s;
  logic b_m;
  logic b_s;
  logic ent_ev;
  logic ext_ev;
  logic [1:0] ab;

  assign ab = {a_s, b_s};

  always_comb begin
    state_d = state_q;
    ent_ev  = 1'b0;
    ext_ev  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ab == 2'b10) state_d = IN1;
        if (ab == 2'b01) state_d = OUT1;
      end
      IN1: begin
        unique case (ab)
          2'b11:   state_d = IN2;
          2'b10:   state_d = IN1;
          default: state_d = IDLE;
        endcase
      end
      IN2: begin
        unique case (ab)
          2'b01:   state_d = IN3;
          2'b10:   state_d = IN1;
          2'b11:   state_d = IN2;
          default: state_d = IDLE;
        endcase
      end
      IN3: begin
        unique case (ab)
          2'b00: begin
            state_d = IDLE;
            ent_ev  = 1'b1;
          end
          2'b11:   state_d = IN2;
          2'b01:   state_d = IN3;
          default: state_d = IDLE;
        endcase
      end
      OUT1: begin
        unique case (ab)
          2'b11:   state_d = OUT2;
          2'b01:   state_d = OUT1;
          default: state_d = IDLE;
        endcase
      end
      OUT2: begin
        unique case (ab)
          2'b10:   state_d = OUT3;
          2'b01:   state_d = OUT1;
          2'b11:   state_d = OUT2;
          default: state_d = IDLE;
        endcase
      end
      OUT3: begin
        unique case (ab)
          2'b00: begin
            state_d = IDLE;
            ext_ev  = 1'b1;
          end
          2'b11:   state_d = OUT2;
          2'b10:   state_d = OUT3;
          default: state_d = IDLE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_m     <= 1'b0;
      a_s     <= 1'b0;
      b_m     <= 1'b0;
      b_s     <= 1'b0;
      state_q <= IDLE;
      enter   <= 1'b0;
      exit    <= 1'b0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      a_m     <= a;
      a_s     <= a_m;
      b_m     <= b;
      b_s     <= b_m;
      state_q <= state_d;
      enter   <= ent_ev;
      exit    <= ext_ev;
      // Saturate instead of wrapping; the overflow is flagged.
      if (ent_ev) begin
        if (count != CAP) count <= count + CW'(1);
        else err <= 1'b1;
      end
      if (ext_ev) begin
        if (count != '0) count <= count - CW'(1);
        else err <= 1'b1;
      end
    end
  end

  assign full  = (count == CAP);
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed vector bench for parking_lot_ctrl at CAPACITY = 3.
// Each row holds a/b for a number of cycles and checks pulses.
module tb_parking_lot_ctrl;

  localparam int CAP = 3;
  localparam int CW = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          enter;
  logic          exit;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          err;

  int n_vec = 0;
  int n_bad = 0;
  int model = 0;

  typedef struct {
    logic a;
    logic b;
    int   hold;
    int   ne;
    int   nx;
    int   cnt;
    int   err;
  } vec_t;

  vec_t tbl[$];

  parking_lot_ctrl #(.CAPACITY(CAP)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .enter (enter),
    .exit  (exit),
    .count (count),
    .full  (full),
    .empty (empty),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model = 0;
    check("rst_count", int'(count), 0);
    check("rst_enter", int'(enter), 0);
    check("rst_exit", int'(exit), 0);
    check("rst_err", int'(err), 0);
    check("rst_full", int'(full), 0);
    check("rst_empty", int'(empty), 1);
    reset = 1'b0;
  endtask

  task automatic apply(input logic va, input logic vb,
                       input int n, output int ne,
                       output int nx);
    ne = 0;
    nx = 0;
    a = va;
    b = vb;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ne += int'(enter);
      nx += int'(exit);
      if (enter && exit) check("both_pulses", 1, 0);
      if (enter && model < CAP) model++;
      if (exit && model > 0) model--;
      check("edge_count", int'(count), model);
      check("edge_full", int'(full), int'(model == CAP));
      check("edge_empty", int'(empty), int'(model == 0));
    end
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int ne;
    int nx;
    apply(v.a, v.b, v.hold, ne, nx);
    check($sformatf("row%0d_enter", idx), ne, v.ne);
    check($sformatf("row%0d_exit", idx), nx, v.nx);
    check($sformatf("row%0d_count", idx),
          int'(count), v.cnt);
    check($sformatf("row%0d_err", idx), int'(err), v.err);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) run_row(tbl[i], i);
    tbl.delete();
  endtask

  initial begin
    // Main table: entries to full, overflow, exits to empty,
    // underflow, then aborted sequences.
    tbl.push_back('{1, 0, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 4, 1, 0, 1, 0});
    tbl.push_back('{1, 0, 4, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 4, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 4, 1, 0, 2, 0});
    tbl.push_back('{1, 0, 4, 0, 0, 2, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 2, 0});
    tbl.push_back('{0, 1, 4, 0, 0, 2, 0});
    tbl.push_back('{0, 0, 4, 1, 0, 3, 0});
    tbl.push_back('{1, 0, 4, 0, 0, 3, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 3, 0});
    tbl.push_back('{0, 1, 4, 0, 0, 3, 0});
    tbl.push_back('{0, 0, 4, 1, 0, 3, 1});
    for (int k = 3; k >= 0; k--) begin
      tbl.push_back('{0, 1, 4, 0, 0, (k > 0) ? k : 0, 1});
      tbl.push_back('{1, 1, 4, 0, 0, (k > 0) ? k : 0, 1});
      tbl.push_back('{1, 0, 4, 0, 0, (k > 0) ? k : 0, 1});
      tbl.push_back('{0, 0, 4, 0, 1,
                      (k > 0) ? k - 1 : 0, 1});
    end
    tbl.push_back('{1, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 4, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 4, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 4, 1, 0, 1, 1});

    do_reset();
    run_tbl();

    // Underflow alone sets err.
    do_reset();
    tbl.push_back('{0, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 4, 0, 1, 0, 1});
    run_tbl();

    // Reset while in IN3 discards the pending entry.
    do_reset();
    tbl.push_back('{1, 0, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 0, 0, 0, 0});
    run_tbl();
    do_reset();
    tbl.push_back('{0, 0, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 4, 1, 0, 1, 0});
    run_tbl();

    // Illegal 11 from idle, then a 1-clk phase mid-sequence.
    do_reset();
    tbl.push_back('{1, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 4, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 4, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 4, 1, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 4, 0, 0, 1, 0});
    run_tbl();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
